instruction_fetch_unit: RTL and testbench

Instruction-fetch (IF) stage of the five-stage MIPS pipeline: owns the program counter, issues word reads to instruction memory, and drives the `instruction` / `PCplus4` pair that the IF/ID pipeline register samples on every rising clock edge.

- IF/ID has no enable, so this block implements stalls by holding its outputs constant.
- It implements bubbles and flushes by driving NOP (`32'h00000000`).
- It accepts PC redirects (taken branch, jump) from later stages.

---
 rtl/instruction_fetch_unit_if.sv | 38 +++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// Perf counter signals exist only when IFETCH_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PCplus4;
  logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, instruction, PCplus4, if_valid,
    output perf_fetched, perf_bubbles
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instruction, PCplus4, if_valid,
    input  perf_fetched, perf_bubbles
  );
`else
  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, instruction, PCplus4, if_valid
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instruction, PCplus4, if_valid
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC, single-outstanding imem read, skid buffer for stalls, NOP bubbles.
// Optional fetch/bubble counters enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_instruction;
  logic [31:0] r_pc_plus4;
  logic        r_if_valid;
  logic [31:0] w_pc_next;

  assign w_pc_next       = r_pc + 32'd4;
  assign bus.imem_req    = (r_state == REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instruction = r_instruction;
  assign bus.PCplus4     = r_pc_plus4;
  assign bus.if_valid    = r_if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_buf_instr   <= 32'h0;
      r_instruction <= 32'h0;
      r_pc_plus4    <= 32'h0;
      r_if_valid    <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect wins over stall; any returning word and the skid buffer are dropped
      r_pc          <= bus.redirect_pc;
      r_instruction <= 32'h0;
      r_if_valid    <= 1'b0;
      r_pc_plus4    <= bus.redirect_pc;
      r_state       <= REQ;
    end else begin
      case (r_state)
        BOOT: r_state <= REQ;
        REQ: begin
          if (bus.imem_ready) begin
            if (!bus.stall) begin
              r_instruction <= bus.imem_rdata;
              r_pc_plus4    <= w_pc_next;
              r_if_valid    <= 1'b1;
              r_pc          <= w_pc_next;
            end else begin
              // IF/ID is frozen, so park the word until the stall clears
              r_buf_instr <= bus.imem_rdata;
              r_state     <= HOLD;
            end
          end else if (!bus.stall) begin
            r_instruction <= 32'h0;
            r_if_valid    <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            r_instruction <= r_buf_instr;
            r_pc_plus4    <= w_pc_next;
            r_if_valid    <= 1'b1;
            r_pc          <= w_pc_next;
            r_state       <= REQ;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic        w_fetch_evt;
  logic        w_bubble_evt;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  assign w_fetch_evt  = !bus.redirect && !bus.stall &&
                        (((r_state == REQ) && bus.imem_ready) || (r_state == HOLD));
  assign w_bubble_evt = bus.redirect ||
                        ((r_state == REQ) && !bus.imem_ready && !bus.stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0;
      r_perf_bubbles <= 32'h0;
    end else begin
      if (w_fetch_evt)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_bubble_evt) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit: per-cycle stimulus with hand-derived
// expected outputs queued at drive time and compared after the following clock edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RPC = 32'h00400000;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  logic clk;
  logic rst_n;
  logic r_ready;
  int   n_checks;
  int   n_errors;
  vec_t vecs[27];
  vec_t exp_q[$];

  instruction_fetch_unit_if ifc();

  instruction_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.master)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  assign ifc.imem_ready = r_ready;
  assign ifc.imem_rdata = mw(ifc.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic [31:0] ei, input logic [31:0] ep,
                              input logic ev, input logic eq, input logic [31:0] ea);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rp; v.ready = rdy;
    v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_req = eq; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    r_ready = 1'b0;
    ifc.stall = 1'b0;
    ifc.redirect = 1'b0;
    ifc.redirect_pc = 32'h0;

    //          stall rd  rpc           rdy  instr                pc4           vld req addr
    vecs[0]  = mk(0, 0, 32'h0,        1, 32'h0,              32'h0,        0, 1, RPC);
    vecs[1]  = mk(0, 0, 32'h0,        1, mw(RPC),            RPC + 4,      1, 1, RPC + 4);
    vecs[2]  = mk(0, 0, 32'h0,        1, mw(RPC + 4),        RPC + 8,      1, 1, RPC + 8);
    vecs[3]  = mk(0, 1, 32'h10,       1, 32'h0,              32'h10,       0, 1, 32'h10);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,              32'h10,       0, 1, 32'h10);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,              32'h10,       0, 1, 32'h10);
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,              32'h10,       0, 1, 32'h10);
    vecs[7]  = mk(0, 0, 32'h0,        1, mw(32'h10),         32'h14,       1, 1, 32'h14);
    vecs[8]  = mk(0, 0, 32'h0,        1, mw(32'h14),         32'h18,       1, 1, 32'h18);
    vecs[9]  = mk(0, 0, 32'h0,        1, mw(32'h18),         32'h1C,       1, 1, 32'h1C);
    vecs[10] = mk(0, 0, 32'h0,        1, mw(32'h1C),         32'h20,       1, 1, 32'h20);
    vecs[11] = mk(1, 0, 32'h0,        1, mw(32'h1C),         32'h20,       1, 0, 32'h20);
    vecs[12] = mk(1, 0, 32'h0,        1, mw(32'h1C),         32'h20,       1, 0, 32'h20);
    vecs[13] = mk(1, 0, 32'h0,        0, mw(32'h1C),         32'h20,       1, 0, 32'h20);
    vecs[14] = mk(1, 0, 32'h0,        1, mw(32'h1C),         32'h20,       1, 0, 32'h20);
    vecs[15] = mk(0, 0, 32'h0,        1, mw(32'h20),         32'h24,       1, 1, 32'h24);
    vecs[16] = mk(0, 0, 32'h0,        1, mw(32'h24),         32'h28,       1, 1, 32'h28);
    vecs[17] = mk(1, 0, 32'h0,        1, mw(32'h24),         32'h28,       1, 0, 32'h28);
    vecs[18] = mk(1, 1, 32'h80,       1, 32'h0,              32'h80,       0, 1, 32'h80);
    vecs[19] = mk(0, 0, 32'h0,        1, mw(32'h80),         32'h84,       1, 1, 32'h84);
    vecs[20] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h0,              32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC);
    vecs[21] = mk(0, 0, 32'h0,        1, mw(32'hFFFFFFFC),   32'h0,        1, 1, 32'h0);
    vecs[22] = mk(0, 0, 32'h0,        1, mw(32'h0),          32'h4,        1, 1, 32'h4);
    vecs[23] = mk(1, 0, 32'h0,        0, mw(32'h0),          32'h4,        1, 1, 32'h4);
    vecs[24] = mk(0, 0, 32'h0,        1, mw(32'h4),          32'h8,        1, 1, 32'h8);
    vecs[25] = mk(0, 1, 32'h100,      1, 32'h0,              32'h100,      0, 1, 32'h100);
    vecs[26] = mk(0, 0, 32'h0,        1, mw(32'h100),        32'h104,      1, 1, 32'h104);

    #12;
    chk("reset instruction", ifc.instruction, 32'h0);
    chk("reset PCplus4", ifc.PCplus4, 32'h0);
    chk("reset if_valid", {31'h0, ifc.if_valid}, 32'h0);
    chk("reset imem_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("reset imem_addr", ifc.imem_addr, RPC);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      vec_t e;
      ifc.stall = vecs[i].stall;
      ifc.redirect = vecs[i].redir;
      ifc.redirect_pc = vecs[i].rpc;
      r_ready = vecs[i].ready;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d instruction", i), ifc.instruction, e.e_instr);
      chk($sformatf("v%0d PCplus4", i), ifc.PCplus4, e.e_pc4);
      chk($sformatf("v%0d if_valid", i), {31'h0, ifc.if_valid}, {31'h0, e.e_valid});
      chk($sformatf("v%0d imem_req", i), {31'h0, ifc.imem_req}, {31'h0, e.e_req});
      chk($sformatf("v%0d imem_addr", i), ifc.imem_addr, e.e_addr);
    end

`ifdef IFETCH_PERF_CNT_EN
    chk("perf_fetched", ifc.perf_fetched, 32'd13);
    chk("perf_bubbles", ifc.perf_bubbles, 32'd7);
`endif

    // Asynchronous reset in the middle of a request cycle
    ifc.stall = 1'b0;
    ifc.redirect = 1'b0;
    r_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst imem_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("async rst imem_addr", ifc.imem_addr, RPC);
    chk("async rst instruction", ifc.instruction, 32'h0);
    chk("async rst PCplus4", ifc.PCplus4, 32'h0);
    chk("async rst if_valid", {31'h0, ifc.if_valid}, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("async rst perf_fetched", ifc.perf_fetched, 32'd0);
    chk("async rst perf_bubbles", ifc.perf_bubbles, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reboot imem_req", {31'h0, ifc.imem_req}, 32'h1);
    chk("reboot if_valid", {31'h0, ifc.if_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("reboot instruction", ifc.instruction, mw(RPC));
    chk("reboot PCplus4", ifc.PCplus4, RPC + 4);
    chk("reboot if_valid 2", {31'h0, ifc.if_valid}, 32'h1);
    chk("reboot imem_addr", ifc.imem_addr, RPC + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
